// File: rtl/wait_ctrl.sv
// Initiator for the WAIT delay handshake: accepts a tick count, pulses start, tracks busy rise/fall, returns done/err.
// Optional busy-cycle counter output is enabled by defining WAITCTRL_CYCCOUNT_EN.
module wait_ctrl #(
    parameter int ARM_TIMEOUT = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_ticks,
    output logic             cmd_ready,
    output logic             start,
    output logic [7:0]       dout,
    input  logic             busy,
    output logic             stall,
    output logic             done,
`ifdef WAITCTRL_CYCCOUNT_EN
    output logic [CNT_W-1:0] busy_cycles,
`endif
    output logic             err
);

    localparam int ARM_W = $clog2(ARM_TIMEOUT);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_BUSY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [7:0]       dout_q, dout_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic             accept;

    assign cmd_ready = (state_q == S_IDLE) && !busy;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        dout_d    = dout_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dout_d  = cmd_ticks;
                    // The WAIT unit ignores zero counts, so skip the handshake entirely.
                    state_d = (cmd_ticks != 8'd0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                arm_cnt_d = '0;
                state_d   = S_ARM;
            end
            S_ARM: begin
                if (busy) begin
                    state_d = S_BUSY;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            S_BUSY: begin
                if (!busy) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_ISSUE);
        done_d  = (state_d == S_DONE);
        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            arm_cnt_q <= '0;
            dout_q    <= 8'd0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            dout_q    <= dout_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign start = start_q;
    assign dout  = dout_q;
    assign done  = done_q;
    assign err   = err_q;
    assign stall = stall_q;

`ifdef WAITCTRL_CYCCOUNT_EN
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    // The busy-high cycle that moves S_ARM to S_BUSY is counted too, so the total equals the busy pulse width.
    always_comb begin
        bcnt_d = bcnt_q;
        if (accept) begin
            bcnt_d = '0;
        end else if (((state_q == S_ARM) || (state_q == S_BUSY)) && busy && (bcnt_q != '1)) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bcnt_q <= '0;
        else     bcnt_q <= bcnt_d;
    end

    assign busy_cycles = bcnt_q;
`endif

endmodule

// File: tb/tb_wait_ctrl.sv
// Scoreboard bench for wait_ctrl: commands push expected completions, a negedge monitor pops them on done.
module tb_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_ticks = 8'd0;
    logic        cmd_ready, start, busy, stall, done, err;
    logic [7:0]  dout;
`ifdef WAITCTRL_CYCCOUNT_EN
    logic [15:0] busy_cycles;
`endif

    logic        force_busy = 1'b0;
    logic        model_en   = 1'b1;
    logic        mb         = 1'b0;
    int unsigned pre = 0, hold = 0, hold_len = 10;

    assign busy = mb | force_busy;

    always #5 clk = ~clk;

    wait_ctrl #(.ARM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ticks   (cmd_ticks),
        .cmd_ready   (cmd_ready),
        .start       (start),
        .dout        (dout),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
`ifdef WAITCTRL_CYCCOUNT_EN
        .busy_cycles (busy_cycles),
`endif
        .err         (err)
    );

    // WAIT unit model: busy rises two cycles after start and stays up for hold_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            mb   <= 1'b0;
            pre  <= 0;
            hold <= 0;
        end else if (start && model_en) begin
            pre  <= 1;
            hold <= hold_len;
        end else if (pre != 0) begin
            pre <= pre - 1;
            if (pre == 1) mb <= 1'b1;
        end else if (mb) begin
            if (hold == 1) mb <= 1'b0;
            hold <= hold - 1;
        end
    end

    typedef struct {
        logic       err;
        int         lat;
        logic [7:0] ticks;
        int         bcyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0, n_fail = 0;
    int         cyc = 0, acc_cyc = 0;
    int         start_cnt = 0, start_rel = 0, done_cnt = 0;
    logic [7:0] start_dout = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cmd_valid && cmd_ready) acc_cyc <= cyc;
    end

    always @(negedge clk) begin
        exp_t e;
        if (start === 1'b1) begin
            start_cnt++;
            start_rel  = cyc - acc_cyc;
            start_dout = dout;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_err", err, e.err);
                chk("done_latency", cyc - acc_cyc, e.lat);
                chk("done_dout", dout, e.ticks);
`ifdef WAITCTRL_CYCCOUNT_EN
                chk("busy_cycles", busy_cycles, e.bcyc);
`endif
            end
        end
    end

    task automatic issue(input logic [7:0] t, input logic e_err, input int lat, input int bc, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clk);
        cmd_ticks = t;
        cmd_valid = 1'b1;
        if (push) begin
            e.err = e_err; e.lat = lat; e.ticks = t; e.bcyc = bc;
            sb.push_back(e);
        end
        #1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("accept_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int stall_lo);
        int n = 0;
        stall_lo = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            if (stall !== 1'b1) stall_lo++;
            @(negedge clk);
            n++;
        end
        if (stall !== 1'b1) stall_lo++;
        chk("done_seen", done, 1);
    endtask

    task automatic run(input logic [7:0] t, input logic e_err, input int lat, input int bc, input int max_cyc);
        int s0, lo;
        s0 = start_cnt;
        issue(t, e_err, lat, bc, 1'b1);
        wait_done(max_cyc, lo);
        chk("stall_low_cycles", lo, 0);
        chk("start_count", start_cnt - s0, (t != 8'd0) ? 1 : 0);
        if (t != 8'd0) begin
            chk("start_cycle", start_rel, 1);
            chk("start_dout", start_dout, t);
        end
        @(negedge clk);
        chk("ready_after_done", cmd_ready, 1);
        chk("idle_stall", stall, 0);
        chk("idle_err", err, 0);
        chk("idle_done", done, 0);
        chk("idle_dout_hold", dout, t);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, n;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_dout", dout, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        run(8'd3, 1'b0, 14, 10, 100);
        run(8'd0, 1'b0, 1, 0, 100);

        model_en = 1'b0;
        run(8'd9, 1'b1, 6, 0, 100);
        model_en = 1'b1;
        run(8'd7, 1'b0, 14, 10, 100);

        // busy held externally while idle blocks acceptance
        s0 = start_cnt;
        @(negedge clk);
        force_busy = 1'b1;
        cmd_ticks  = 8'd5;
        cmd_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("blocked_ready", cmd_ready, 0);
            chk("blocked_stall", stall, 0);
        end
        chk("blocked_no_start", start_cnt - s0, 0);
        begin
            exp_t e;
            e.err = 1'b0; e.lat = 14; e.ticks = 8'd5; e.bcyc = 10;
            sb.push_back(e);
        end
        force_busy = 1'b0;
        #1;
        chk("unblocked_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(100, n);
        chk("unblocked_stall_low", n, 0);
        chk("unblocked_start_count", start_cnt - s0, 1);

        // reset in the middle of S_BUSY
        issue(8'd3, 1'b0, 0, 0, 1'b0);
        n = 0;
        while (!(busy === 1'b1 && stall === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_busy", busy & stall, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_start", start, 0);
        chk("midrst_done", done, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_dout", dout, 0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", done_cnt - d0, 0);

        run(8'd200, 1'b0, 14, 10, 100);

`ifdef WAITCTRL_CYCCOUNT_EN
        hold_len = 70000;
        run(8'd1, 1'b0, 70004, 65535, 70100);
        hold_len = 10;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
